switch_led_ctrl: RTL and testbench

SWITCH_LED_CTRL -- requirements
Module: switch_led_ctrl

---
 rtl/switch_led_pkg.sv | 27 ++
 rtl/sw_debounce.sv | 59 +++++
 rtl/switch_led_ctrl.sv | 114 +++++++++++
 tb/tb_switch_led_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_led_pkg.sv
// Shared pattern-state encoding and sequencing for the switch/LED controller.
// Imported by the FSM top so encodings live in one place.
package switch_led_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_OFF   = 2'd0,
        S_LOW   = 2'd1,
        S_HIGH  = 2'd2,
        S_CHASE = 2'd3
    } state_e;

    // sw1 press sequence in latched mode; chase loops back to low half.
    function automatic state_e next_on_press(input state_e s);
        state_e n;
        n = S_LOW;
        unique case (s)
            S_OFF:   n = S_LOW;
            S_LOW:   n = S_HIGH;
            S_HIGH:  n = S_CHASE;
            S_CHASE: n = S_LOW;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser, counter debounce and rising-edge press pulse
// for one asynchronous switch input.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count only runs while the input disagrees; any agreement restarts it.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/switch_led_ctrl.sv
// Two-switch LED pattern controller: debounced inputs drive a level-
// following or press-latched pattern FSM with a one-hot chase pattern.
module switch_led_ctrl
    import switch_led_pkg::*;
#(
    parameter int NLEDS           = 8,
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int SHIFT_DIV       = 1200000,
    parameter int LATCH_MODE      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw1,
    input  logic               sw2,
    output logic [NLEDS-1:0]   leds,
    output logic [STATE_W-1:0] mode
);

    localparam int HALF   = NLEDS / 2;
    localparam int STEP_W = $clog2(SHIFT_DIV + 1);

    localparam logic [NLEDS-1:0] LOW_PAT  = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [NLEDS-1:0] HIGH_PAT = {{HALF{1'b1}}, {HALF{1'b0}}};
    localparam logic [NLEDS-1:0] ONE_PAT  = {{(NLEDS-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SHIFT_DIV - 1);

    logic lvl1;
    logic lvl2;
    logic prs1;
    logic prs2;

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_sw1 (
        .clk   (clk),
        .rst   (rst),
        .sw_in (sw1),
        .level (lvl1),
        .press (prs1)
    );

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_sw2 (
        .clk   (clk),
        .rst   (rst),
        .sw_in (sw2),
        .level (lvl2),
        .press (prs2)
    );

    state_e             state_q;
    state_e             state_d;
    logic [NLEDS-1:0]   leds_q;
    logic [NLEDS-1:0]   leds_d;
    logic [STEP_W-1:0]  step_q;
    logic [STEP_W-1:0]  step_d;

    always_comb begin
        state_d = state_q;
        if (LATCH_MODE == 0) begin
            if (lvl1) begin
                state_d = S_LOW;
            end else if (lvl2) begin
                state_d = S_OFF;
            end else begin
                state_d = S_HIGH;
            end
        end else begin
            if (prs2) begin
                state_d = S_OFF;
            end else if (prs1) begin
                state_d = next_on_press(state_q);
            end
        end
    end

    // Chase restarts from LED1 on every entry, then rotates each step wrap.
    always_comb begin
        leds_d = '0;
        step_d = '0;
        unique case (state_d)
            S_OFF:  leds_d = '0;
            S_LOW:  leds_d = LOW_PAT;
            S_HIGH: leds_d = HIGH_PAT;
            S_CHASE: begin
                if (state_q != S_CHASE) begin
                    leds_d = ONE_PAT;
                end else if (step_q == STEP_LAST) begin
                    leds_d = {leds_q[NLEDS-2:0], leds_q[NLEDS-1]};
                end else begin
                    leds_d = leds_q;
                    step_d = step_q + STEP_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OFF;
            leds_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            leds_q  <= leds_d;
            step_q  <= step_d;
        end
    end

    assign leds = leds_q;
    assign mode = state_q;

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed bench for switch_led_ctrl: one latched and one level-mode
// instance with short debounce and chase periods.
module tb_switch_led_ctrl;

    logic       clk;
    logic       rst;
    logic       sw1;
    logic       sw2;
    logic [7:0] leds;
    logic [1:0] mode;
    logic       lsw1;
    logic       lsw2;
    logic [7:0] lleds;
    logic [1:0] lmode;

    int vectors;
    int miscompares;

    switch_led_ctrl #(
        .NLEDS(8), .DEBOUNCE_CYCLES(4), .SHIFT_DIV(3), .LATCH_MODE(1)
    ) dut_latch (
        .clk(clk), .rst(rst), .sw1(sw1), .sw2(sw2),
        .leds(leds), .mode(mode)
    );

    switch_led_ctrl #(
        .NLEDS(8), .DEBOUNCE_CYCLES(4), .SHIFT_DIV(3), .LATCH_MODE(0)
    ) dut_level (
        .clk(clk), .rst(rst), .sw1(lsw1), .sw2(lsw2),
        .leds(lleds), .mode(lmode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        vectors++;
        if (leds !== 8'h00 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_latch leds=%h mode=%0d exp 00/0", leds, mode);
        end
        vectors++;
        if (lleds !== 8'h00 || lmode !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_level leds=%h mode=%0d exp 00/0", lleds, lmode);
        end
        rst = 1'b0;
        tick(12);
        vectors++;
        if (leds !== 8'h00 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL idle leds=%h mode=%0d exp 00/0", leds, mode);
        end
    endtask

    task automatic test_bounce_press();
        sw1 = 1'b1;
        tick(1);
        sw1 = 1'b0;
        tick(1);
        sw1 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            vectors++;
            if (leds !== 8'h00) begin
                miscompares++;
                $display("FAIL bounce_hold t=%0d leds=%h exp 00", i, leds);
            end
        end
        tick(1);
        vectors++;
        if (leds !== 8'h0F || mode !== 2'd1) begin
            miscompares++;
            $display("FAIL press1 leds=%h mode=%0d exp 0F/1", leds, mode);
        end
        sw1 = 1'b0;
        tick(10);
        vectors++;
        if (leds !== 8'h0F) begin
            miscompares++;
            $display("FAIL release1 leds=%h exp 0F", leds);
        end
        sw1 = 1'b1;
        tick(6);
        vectors++;
        if (leds !== 8'h0F) begin
            miscompares++;
            $display("FAIL press2_early leds=%h exp 0F", leds);
        end
        tick(1);
        vectors++;
        if (leds !== 8'hF0 || mode !== 2'd2) begin
            miscompares++;
            $display("FAIL press2 leds=%h mode=%0d exp F0/2", leds, mode);
        end
        sw1 = 1'b0;
        tick(10);
        sw1 = 1'b1;
        tick(7);
        vectors++;
        if (leds !== 8'h01 || mode !== 2'd3) begin
            miscompares++;
            $display("FAIL press3 leds=%h mode=%0d exp 01/3", leds, mode);
        end
        sw1 = 1'b0;
    endtask

    task automatic test_chase();
        logic [7:0] exp;
        for (int k = 1; k <= 27; k++) begin
            tick(1);
            exp = 8'h01 << ((k / 3) % 8);
            vectors++;
            if (leds !== exp || mode !== 2'd3) begin
                miscompares++;
                $display("FAIL chase k=%0d leds=%h mode=%0d exp %h/3",
                         k, leds, mode, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        int changes;
        logic [1:0] prev;
        sw1 = 1'b1;
        tick(7);
        vectors++;
        if (leds !== 8'h0F || mode !== 2'd1) begin
            miscompares++;
            $display("FAIL chase_to_low leds=%h mode=%0d exp 0F/1", leds, mode);
        end
        sw1 = 1'b0;
        tick(10);
        sw1 = 1'b1;
        tick(7);
        sw1 = 1'b0;
        tick(10);
        vectors++;
        if (leds !== 8'hF0 || mode !== 2'd2) begin
            miscompares++;
            $display("FAIL to_high leds=%h mode=%0d exp F0/2", leds, mode);
        end
        sw1 = 1'b1;
        sw2 = 1'b1;
        tick(6);
        vectors++;
        if (leds !== 8'hF0) begin
            miscompares++;
            $display("FAIL both_early leds=%h exp F0", leds);
        end
        tick(1);
        vectors++;
        if (leds !== 8'h00 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL both_press leds=%h mode=%0d exp 00/0", leds, mode);
        end
        sw1 = 1'b0;
        sw2 = 1'b0;
        tick(10);
        changes = 0;
        prev = mode;
        sw1 = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            if (mode !== prev) changes++;
            prev = mode;
            if (i == 7) begin
                vectors++;
                if (leds !== 8'h0F || mode !== 2'd1) begin
                    miscompares++;
                    $display("FAIL held_press leds=%h mode=%0d exp 0F/1",
                             leds, mode);
                end
            end
        end
        vectors++;
        if (changes != 1 || mode !== 2'd1) begin
            miscompares++;
            $display("FAIL held_once changes=%0d mode=%0d exp 1/1",
                     changes, mode);
        end
        sw1 = 1'b0;
        tick(10);
    endtask

    task automatic test_level();
        vectors++;
        if (lleds !== 8'hF0 || lmode !== 2'd2) begin
            miscompares++;
            $display("FAIL lvl_idle leds=%h mode=%0d exp F0/2", lleds, lmode);
        end
        lsw1 = 1'b1;
        tick(6);
        vectors++;
        if (lleds !== 8'hF0) begin
            miscompares++;
            $display("FAIL lvl_sw1_early leds=%h exp F0", lleds);
        end
        tick(1);
        vectors++;
        if (lleds !== 8'h0F || lmode !== 2'd1) begin
            miscompares++;
            $display("FAIL lvl_sw1 leds=%h mode=%0d exp 0F/1", lleds, lmode);
        end
        lsw1 = 1'b0;
        lsw2 = 1'b1;
        tick(6);
        vectors++;
        if (lleds !== 8'h0F) begin
            miscompares++;
            $display("FAIL lvl_sw2_early leds=%h exp 0F", lleds);
        end
        tick(1);
        vectors++;
        if (lleds !== 8'h00 || lmode !== 2'd0) begin
            miscompares++;
            $display("FAIL lvl_sw2 leds=%h mode=%0d exp 00/0", lleds, lmode);
        end
        lsw2 = 1'b0;
        tick(6);
        vectors++;
        if (lleds !== 8'h00) begin
            miscompares++;
            $display("FAIL lvl_none_early leds=%h exp 00", lleds);
        end
        tick(1);
        vectors++;
        if (lleds !== 8'hF0 || lmode !== 2'd2) begin
            miscompares++;
            $display("FAIL lvl_none leds=%h mode=%0d exp F0/2", lleds, lmode);
        end
        lsw1 = 1'b1;
        lsw2 = 1'b1;
        tick(6);
        vectors++;
        if (lleds !== 8'hF0) begin
            miscompares++;
            $display("FAIL lvl_both_early leds=%h exp F0", lleds);
        end
        tick(1);
        vectors++;
        if (lleds !== 8'h0F || lmode !== 2'd1) begin
            miscompares++;
            $display("FAIL lvl_both leds=%h mode=%0d exp 0F/1", lleds, lmode);
        end
        lsw1 = 1'b0;
        lsw2 = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid();
        sw1 = 1'b1;
        tick(7);
        sw1 = 1'b0;
        tick(10);
        sw1 = 1'b1;
        tick(7);
        vectors++;
        if (leds !== 8'h01 || mode !== 2'd3) begin
            miscompares++;
            $display("FAIL rm_chase leds=%h mode=%0d exp 01/3", leds, mode);
        end
        sw1 = 1'b0;
        tick(10);
        sw1 = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(1);
        vectors++;
        if (leds !== 8'h00 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL rm_reset leds=%h mode=%0d exp 00/0", leds, mode);
        end
        rst = 1'b0;
        sw1 = 1'b0;
        tick(20);
        vectors++;
        if (leds !== 8'h00 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL rm_after leds=%h mode=%0d exp 00/0", leds, mode);
        end
    endtask

    task automatic test_reset_held();
        sw1 = 1'b1;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
        vectors++;
        if (leds !== 8'h00 || mode !== 2'd0) begin
            miscompares++;
            $display("FAIL rh_early leds=%h mode=%0d exp 00/0", leds, mode);
        end
        tick(1);
        vectors++;
        if (leds !== 8'h0F || mode !== 2'd1) begin
            miscompares++;
            $display("FAIL rh_press leds=%h mode=%0d exp 0F/1", leds, mode);
        end
        tick(20);
        vectors++;
        if (leds !== 8'h0F || mode !== 2'd1) begin
            miscompares++;
            $display("FAIL rh_hold leds=%h mode=%0d exp 0F/1", leds, mode);
        end
        sw1 = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b1;
        sw1  = 1'b0;
        sw2  = 1'b0;
        lsw1 = 1'b0;
        lsw2 = 1'b0;
        test_reset();
        test_bounce_press();
        test_chase();
        test_simultaneous();
        test_level();
        test_reset_mid();
        test_reset_held();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
